// File: rtl/calc_tile_r_max_pkg.sv
// Shared definitions for the tile_R_max calculator: kernel encoding,
// stride legality, KH lookup, default buffer sizing and divider length.
// Optional build macro: CALC_TILE_R_EVEN_EN (used in calc_tile_r_max.sv).
package calc_tile_pkg;

  typedef enum logic [1:0] {
    KS_PW  = 2'd1,
    KS_DW3 = 2'd2
  } ks_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPER,
    ST_DIV,
    ST_FIN
  } calc_state_e;

  localparam logic [1:0] STRIDE_MIN = 2'd1;
  localparam logic [1:0] STRIDE_MAX = 2'd2;

  localparam int GLB_BYTES_DEF   = 65536;
  localparam int PSUM_BYTES_DEF  = 2;
  localparam int R_MAX_LIMIT_DEF = 127;

  localparam int DIV_W     = 17;
  localparam int DIV_ITERS = 17;

  // Kernel height for a kernel_size code; 0 marks an illegal code.
  function automatic logic [1:0] kh_of(input logic [1:0] ks);
    case (ks)
      2'd1:    kh_of = 2'd1;
      2'd2:    kh_of = 2'd3;
      default: kh_of = 2'd0;
    endcase
  endfunction

  function automatic logic stride_ok(input logic [1:0] s);
    stride_ok = (s >= STRIDE_MIN) && (s <= STRIDE_MAX);
  endfunction

endpackage

// File: rtl/calc_tile_r_max_if.sv
// Request/response bundle of the tile_R_max calculator.
interface calc_tile_r_max_if;
  logic       start;
  logic [1:0] kernel_size;
  logic [1:0] stride;
  logic [6:0] padded_C;
  logic [6:0] tile_D;
  logic [6:0] tile_K;
  logic [6:0] out_C;
  logic       busy;
  logic       done;
  logic [6:0] tile_R_max;
  logic       cfg_err;

  modport master (
    output start, kernel_size, stride, padded_C, tile_D, tile_K, out_C,
    input  busy, done, tile_R_max, cfg_err
  );

  modport slave (
    input  start, kernel_size, stride, padded_C, tile_D, tile_K, out_C,
    output busy, done, tile_R_max, cfg_err
  );
endinterface

// File: rtl/calc_tile_r_max_tile_div_u.sv
// Restoring unsigned divider, one quotient bit per iterate cycle.
// After load plus W iterate cycles, quotient holds floor(dividend/divisor).
module tile_div_u
  import calc_tile_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         iter,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient
);

  logic [W:0]   rem_q;
  logic [W-1:0] quo_q;
  logic [W-1:0] div_q;
  logic [W:0]   shl;

  // Partial remainder shifted left with the next dividend bit brought in.
  always_comb shl = {rem_q[W-1:0], quo_q[W-1]};

  // Load operands or perform one restoring step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      div_q <= divisor;
    end else if (iter) begin
      if (shl >= {1'b0, div_q}) begin
        rem_q <= shl - {1'b0, div_q};
        quo_q <= {quo_q[W-2:0], 1'b1};
      end else begin
        rem_q <= shl;
        quo_q <= {quo_q[W-2:0], 1'b0};
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/calc_tile_r_max.sv
// tile_R_max calculator: largest output-row count per tile that fits the GLB.
// Build macro CALC_TILE_R_EVEN_EN: round results >=2 down to an even value.
//
// state   | meaning
// IDLE    | waiting for start
// OPER    | operands computed, divider loaded
// DIV     | 17 restoring-division iterations
// FIN     | clamp, register result, pulse done
module calc_tile_r_max
  import calc_tile_pkg::*;
#(
  parameter int GLB_BYTES   = GLB_BYTES_DEF,
  parameter int PSUM_BYTES  = PSUM_BYTES_DEF,
  parameter int R_MAX_LIMIT = R_MAX_LIMIT_DEF
) (
  input logic               clk,
  input logic               rst,
  calc_tile_r_max_if.slave  bus
);

  calc_state_e state_q, state_d;
  logic        accept, div_load, div_iter, finish;
  logic [4:0]  cnt_q;

  logic [1:0]  ks_q, stride_q;
  logic [6:0]  pc_q, d_q, k_q, oc_q;
  logic        err_pre_q;

  logic        done_q, err_q;
  logic [6:0]  r_q;

  logic [1:0]         kh;
  logic               is_pw;
  logic [6:0]         oc_sel;
  logic [13:0]        w, in_row;
  logic signed [19:0] khs, num;
  logic [19:0]        den;
  logic               cfg_bad, zero_dim, num_ok, den_ok, err_pre_d;
  logic [DIV_W-1:0]   div_num, div_den, quo;

  logic [6:0]  clamped, r_fin;
  logic        err_fin;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    div_load = 1'b0;
    div_iter = 1'b0;
    finish   = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = ST_OPER;
      end
      ST_OPER: begin
        div_load = 1'b1;
        state_d  = ST_DIV;
      end
      ST_DIV: begin
        div_iter = 1'b1;
        if (cnt_q == 5'd0) state_d = ST_FIN;
      end
      ST_FIN: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration down-counter; terminal count ends the DIV phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt_q <= '0;
    else if (div_load)                  cnt_q <= 5'(DIV_ITERS - 1);
    else if (div_iter && cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
  end

  // Capture request fields on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_q     <= '0;
      stride_q <= '0;
      pc_q     <= '0;
      d_q      <= '0;
      k_q      <= '0;
      oc_q     <= '0;
    end else if (accept) begin
      ks_q     <= bus.kernel_size;
      stride_q <= bus.stride;
      pc_q     <= bus.padded_C;
      d_q      <= bus.tile_D;
      k_q      <= bus.tile_K;
      oc_q     <= bus.out_C;
    end
  end

  // Operand computation: numerator is signed because (KH - stride) can be -1.
  always_comb begin
    kh       = kh_of(ks_q);
    is_pw    = (ks_q == KS_PW);
    oc_sel   = is_pw ? k_q : d_q;
    w        = is_pw ? 14'(d_q) * 14'(k_q) : 14'(d_q) * 14'd9;
    in_row   = 14'(pc_q) * 14'(d_q);
    khs      = $signed(20'(kh)) - $signed(20'(stride_q));
    num      = $signed(20'(GLB_BYTES)) - $signed(20'(w)) - khs * $signed(20'(in_row));
    den      = 20'(stride_q) * 20'(in_row)
             + 20'(PSUM_BYTES) * 20'(oc_q) * 20'(oc_sel);
    cfg_bad  = (kh == 2'd0) || !stride_ok(stride_q);
    zero_dim = (pc_q == 7'd0) || (d_q == 7'd0) || (oc_q == 7'd0) || (is_pw && k_q == 7'd0);
    num_ok   = !num[19] && (num != 20'sd0) && (num[19:17] == 3'd0);
    den_ok   = (den != 20'd0) && (den[19:17] == 3'd0);
    err_pre_d = cfg_bad || zero_dim || !num_ok || !den_ok;
    div_num  = num_ok ? num[16:0] : '0;
    div_den  = den_ok ? den[16:0] : 17'd1;
  end

  // Early error flag captured alongside the divider load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           err_pre_q <= 1'b0;
    else if (div_load) err_pre_q <= err_pre_d;
  end

  tile_div_u #(.W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .iter     (div_iter),
    .dividend (div_num),
    .divisor  (div_den),
    .quotient (quo)
  );

  // Clamp, optional even rounding, and error folding of the quotient.
  always_comb begin
    clamped = (quo > DIV_W'(R_MAX_LIMIT)) ? 7'(R_MAX_LIMIT) : quo[6:0];
`ifdef CALC_TILE_R_EVEN_EN
    r_fin = (clamped >= 7'd2) ? {clamped[6:1], 1'b0} : clamped;
`else
    r_fin = clamped;
`endif
    err_fin = err_pre_q || (quo == '0);
  end

  // Result registers; only the finishing cycle updates them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
      r_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        r_q   <= err_fin ? 7'd0 : r_fin;
        err_q <= err_fin;
      end
    end
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.tile_R_max = r_q;
  assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_calc_tile_r_max.sv
// Scoreboard bench for calc_tile_r_max with directed, hand-computed vectors.
module tb_calc_tile_r_max;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  calc_tile_r_max_if bus();

  calc_tile_r_max dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0] r;
    logic       e;
    int         acc;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [1:0] ks;
    logic [1:0] s;
    logic [6:0] pc;
    logic [6:0] d;
    logic [6:0] k;
    logic [6:0] oc;
    logic [6:0] r;
    logic       e;
  } vec_t;

`ifdef CALC_TILE_R_EVEN_EN
  localparam logic [6:0] R_DW  = 7'd22;
  localparam logic [6:0] R_CLP = 7'd126;
`else
  localparam logic [6:0] R_DW  = 7'd23;
  localparam logic [6:0] R_CLP = 7'd127;
`endif

  vec_t vecs[9] = '{
    '{2'd1, 2'd1, 7'd112, 7'd8,   7'd16,  7'd112, 7'd14, 1'b0},
    '{2'd2, 2'd1, 7'd112, 7'd8,   7'd16,  7'd112, R_DW,  1'b0},
    '{2'd1, 2'd1, 7'd1,   7'd1,   7'd1,   7'd1,   R_CLP, 1'b0},
    '{2'd0, 2'd1, 7'd112, 7'd8,   7'd16,  7'd112, 7'd0,  1'b1},
    '{2'd1, 2'd3, 7'd112, 7'd8,   7'd16,  7'd112, 7'd0,  1'b1},
    '{2'd1, 2'd1, 7'd112, 7'd0,   7'd16,  7'd112, 7'd0,  1'b1},
    '{2'd1, 2'd1, 7'd127, 7'd127, 7'd127, 7'd127, 7'd1,  1'b0},
    '{2'd1, 2'd2, 7'd112, 7'd8,   7'd16,  7'd56,  7'd18, 1'b0},
    '{2'd2, 2'd1, 7'd127, 7'd127, 7'd0,   7'd127, 7'd0,  1'b1}
  };

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive_idle();
    bus.start       = 1'b0;
    bus.kernel_size = 2'd0;
    bus.stride      = 2'd0;
    bus.padded_C    = 7'd0;
    bus.tile_D      = 7'd0;
    bus.tile_K      = 7'd0;
    bus.out_C       = 7'd0;
  endtask

  // Called at a negedge; waits for busy=0, pulses start for one cycle.
  task automatic issue(input vec_t v, input bit push);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle_wait: busy stuck at %0b, required 0", bus.busy);
    end
    bus.start       = 1'b1;
    bus.kernel_size = v.ks;
    bus.stride      = v.s;
    bus.padded_C    = v.pc;
    bus.tile_D      = v.d;
    bus.tile_K      = v.k;
    bus.out_C       = v.oc;
    if (push) exp_q.push_back('{v.r, v.e, cyc + 1});
    @(posedge clk);
    #1;
    chk("busy_rise", int'(bus.busy), 1);
    @(negedge clk);
    drive_idle();
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required none", cyc);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("tile_R_max", int'(bus.tile_R_max), int'(x.r));
        chk("cfg_err", int'(bus.cfg_err), int'(x.e));
        chk("latency", cyc - x.acc, 19);
        chk("busy_at_done", int'(bus.busy), 0);
      end
    end
  end

  initial begin
    vec_t v;
    int   n;
    drive_idle();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_r", int'(bus.tile_R_max), 0);
    chk("rst_err", int'(bus.cfg_err), 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) issue(vecs[i], 1'b1);

    // start while busy must be ignored
    issue(vecs[0], 1'b1);
    repeat (3) @(negedge clk);
    v = vecs[1];
    bus.start = 1'b1; bus.kernel_size = v.ks; bus.stride = v.s;
    bus.padded_C = v.pc; bus.tile_D = v.d; bus.tile_K = v.k; bus.out_C = v.oc;
    @(negedge clk);
    drive_idle();

    // back-to-back: new start in the cycle done is high
    issue(vecs[6], 1'b1);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", int'(bus.done), 1);
    issue(vecs[7], 1'b1);

    // reset mid-operation aborts without a done
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    issue(vecs[0], 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_r", int'(bus.tile_R_max), 0);
    chk("abort_err", int'(bus.cfg_err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("abort_idle", int'(bus.busy), 0);

    issue(vecs[1], 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", exp_q.size(), 0);
    repeat (25) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_tile_r_max.md
Name: calc_tile_r_max

Overview:
- Layer-decoder helper that computes tile_R_max, the largest number of output rows per tile for which one tile's data fits in the global buffer (GLB).
- The tile's data is weights, input rows and 16-bit partial-sum output rows.
- Sits between layer-descriptor decode and the tiling/address generators.
- Sequential: a start/done handshake drives a bit-serial unsigned divider.

Parameters:
- GLB_BYTES, 65536, GLB capacity in bytes (must be below 2^17).
- PSUM_BYTES, 2, bytes per output element (partial sum).
- R_MAX_LIMIT, 127, upper clamp on the result (fits 7 bits).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; inputs are sampled on the same edge.
- kernel_size  input  2  1 = 1x1 pointwise (KH=1); 2 = 3x3 depthwise (KH=3); 0 and 3 are illegal.
- stride  input  2  legal values 1 and 2; others are illegal.
- padded_C  input  7  padded input width (columns).
- tile_D  input  7  input channels per tile.
- tile_K  input  7  output channels per tile (pointwise only).
- out_C  input  7  output width (columns).
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when tile_R_max is valid.
- tile_R_max  output  7  result; held until the next done.
- cfg_err  output  1  error flag; updated together with done.

Behaviour:
- Reset: busy=0, done=0, tile_R_max=0, cfg_err=0; any in-flight computation is aborted, including reset asserted mid-operation.
- Handshake:
  - start is accepted only when busy=0; start while busy=1 is ignored.
  - Inputs are latched at the accept edge T; busy rises at T.
  - done=1 and busy=0 at edge T+19, so a new start can be accepted at edge T+19.
  - A start asserted in the same cycle done is high is accepted.
- Pipeline:
  - Cycle 1: compute operands.
  - Cycles 2-18: 17 restoring-division iterations, one quotient bit each.
  - Cycle 19: clamp and register the result.
- Arithmetic (unsigned products; signed 20-bit numerator check):
  - OC = tile_K if kernel_size=1, OC = tile_D if kernel_size=2.
  - W = tile_D*tile_K if kernel_size=1, W = tile_D*9 if kernel_size=2.
  - IN_ROW = padded_C*tile_D.
  - NUM = GLB_BYTES - W - (KH - stride)*IN_ROW.
  - DEN = stride*IN_ROW + PSUM_BYTES*out_C*OC.
  - tile_R_max = min(floor(NUM/DEN), R_MAX_LIMIT).
- Error and boundary handling:
  - Illegal kernel_size or stride: cfg_err=1, tile_R_max=0.
  - DEN=0 (any zero dimension) or NUM<=0: cfg_err=1, tile_R_max=0.
  - Quotient 0 with NUM>0 (one row does not fit): cfg_err=1, tile_R_max=0.
  - Latency stays 19 cycles in every error case.
  - cfg_err and tile_R_max update only at done.

Optional Feature:
- Macro CALC_TILE_R_EVEN_EN.
- Defined: a clamped quotient >=2 is rounded down to an even value (LSB cleared); a quotient of 1 stays 1. Latency is unchanged.
- Undefined: the raw clamped quotient is output.

Decomposition:
- Package calc_tile_pkg holds:
  - the kernel_size encoding enum (KS_PW=1, KS_DW3=2);
  - the stride legality constants;
  - the KH lookup;
  - the default GLB_BYTES/PSUM_BYTES constants;
  - the divider iteration count, 17.
- One sub-module, tile_div_u: a 17-bit/17-bit restoring unsigned divider with load/iterate control, one bit per cycle.

Test Plan (macro undefined unless noted):
- kernel_size=1, stride=1, padded_C=112, tile_D=8, tile_K=16, out_C=112, start -> done at T+19, tile_R_max=14, cfg_err=0.
- kernel_size=2, stride=1, padded_C=112, tile_D=8, tile_K=16, out_C=112 -> tile_R_max=23, cfg_err=0. With CALC_TILE_R_EVEN_EN -> 22.
- kernel_size=1, stride=1, padded_C=1, tile_D=1, tile_K=1, out_C=1 (quotient 21845) -> tile_R_max=127 (clamp), cfg_err=0.
- kernel_size=0 or stride=3 -> done at T+19, tile_R_max=0, cfg_err=1. Also tile_D=0 -> cfg_err=1.
- kernel_size=1, stride=1, padded_C=127, tile_D=127, tile_K=127, out_C=127:
  - NUM = 65536 - 16129 = 49407; DEN = 16129 + 2*16129 = 48387.
  - Expect tile_R_max=1, cfg_err=0.
- Handshake and reset:
  - start pulsed again while busy -> ignored.
  - rst asserted at T+10 -> all outputs 0 at once, no done.
  - back-to-back start on the done cycle -> accepted, second done 19 cycles later.
